// File: rtl/boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings and header width.
package boot_loader_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StHdr  = ST_HDR,
        StLoad = ST_LOAD,
        StChk  = ST_CHK,
        StRun  = ST_RUN,
        StErr  = ST_ERR
    } state_e;

    // Header length field is one bit wider than the address so it can express DEPTH itself.
    function automatic int unsigned hdr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream feeding the boot loader (header, image words, optional checksum).
interface imem_boot_loader_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/boot_checksum.sv
// XOR accumulator over image words; clear has priority over enable.
module boot_checksum #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q ^ data;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory, then enables the core.
// Optional trailing XOR checksum word when BOOT_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                core_en,
    output logic                load_done,
    output logic                load_err
);

    localparam int unsigned HdrW = hdr_w(ADDR_W);
    localparam logic [HdrW-1:0] Depth = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [HdrW-1:0]   len_q, len_d;
    logic [HdrW-1:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic              ready;
    logic              accept;
    logic [HdrW-1:0]   hdr_len;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic              chk_clr;
    logic              chk_en;
    logic [DATA_W-1:0] chk_acc;

    boot_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (chk_clr),
        .en   (chk_en),
        .data (bus.data_in),
        .acc  (chk_acc)
    );
`endif

    assign ready          = (state_q == StHdr) || (state_q == StLoad) || (state_q == StChk);
    assign bus.data_ready = ready;
    assign accept         = bus.data_valid && ready;
    assign hdr_len        = bus.data_in[HdrW-1:0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk_clr = 1'b0;
        chk_en  = 1'b0;
`endif
        unique case (state_q)
            StIdle, StRun, StErr: begin
                if (start) begin
                    state_d = StHdr;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    chk_clr = 1'b1;
`endif
                end
            end
            StHdr: begin
                if (accept) begin
                    len_d   = hdr_len;
                    count_d = '0;
                    state_d = (hdr_len == '0 || hdr_len > Depth) ? StErr : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = bus.data_in;
                    count_d = count_q + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    chk_en  = 1'b1;
                    if (count_d == len_q) state_d = StChk;
`else
                    if (count_d == len_q) state_d = StRun;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) state_d = (bus.data_in == chk_acc) ? StRun : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Holding run low while entering RUN delays core_en past the final memory write.
    assign run_d = (state_q == StRun) && (state_d == StRun);
    assign err_d = (state_d == StErr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_en    = run_q;
    assign load_done  = run_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as words are driven.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_en;
    logic              load_done;
    logic              load_err;

    imem_boot_loader_if #(.DATA_W(DATA_W)) bus ();

    imem_boot_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_en    (core_en),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", {32'd0, imem_wdata}, 64'hffff_ffff_ffff_ffff);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("we_addr", 64'(imem_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("we_data", 64'(imem_wdata), 64'(e[DATA_W-1:0]));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        int i;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        i = 0;
        while (!bus.data_ready && i < 20) begin
            cycle();
            i++;
        end
        if (!bus.data_ready) check("ready_timeout", 64'(bus.data_ready), 64'd1);
        cycle();
        bus.data_valid = 1'b0;
    endtask

    task automatic start_image(input logic [DATA_W-1:0] hdr);
        pulse_start();
        acc = '0;
        send_word(hdr);
    endtask

    task automatic load_word(input int addr, input logic [DATA_W-1:0] w);
        exp_q.push_back({addr[ADDR_W-1:0], w});
        acc ^= w;
        send_word(w);
    endtask

    task automatic finish_image();
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(acc);
`endif
    endtask

    task automatic wait_run(input string tag);
        int i;
        i = 0;
        while (core_en !== 1'b1 && i < 20) begin
            cycle();
            i++;
        end
        check(tag, 64'(core_en), 64'd1);
    endtask

    initial begin
        int w0;
        rst = 1'b0;
        start = 1'b0;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        repeat (3) cycle();
        check("rst_we", 64'(imem_we), 0);
        check("rst_addr", 64'(imem_addr), 0);
        check("rst_wdata", 64'(imem_wdata), 0);
        check("rst_core_en", 64'(core_en), 0);
        check("rst_done", 64'(load_done), 0);
        check("rst_err", 64'(load_err), 0);
        check("rst_ready", 64'(bus.data_ready), 0);
        rst = 1'b1;
        cycle();

        // Back-to-back three-word image; core_en must follow the last write by one cycle.
        w0 = n_writes;
        start_image(32'd3);
        load_word(0, 32'h0050_0093);
        load_word(1, 32'h00a0_0113);
        load_word(2, 32'h0020_81b3);
        finish_image();
        check("t1_en_early", 64'(core_en), 0);
        cycle();
        check("t1_core_en", 64'(core_en), 1);
        check("t1_done", 64'(load_done), 1);
        check("t1_we_idle", 64'(imem_we), 0);
        check("t1_writes", 64'(n_writes - w0), 3);

        // Illegal headers, then recovery; upper header bits must be ignored.
        w0 = n_writes;
        start_image(32'd0);
        check("t2_err0", 64'(load_err), 1);
        check("t2_core_off0", 64'(core_en), 0);
        check("t2_ready_err", 64'(bus.data_ready), 0);
        pulse_start();
        check("t2_err_clr", 64'(load_err), 0);
        send_word(32'd33);
        check("t2_err33", 64'(load_err), 1);
        check("t2_done33", 64'(load_done), 0);
        check("t2_nowrite", 64'(n_writes - w0), 0);
        start_image(32'hffff_ffc1);
        load_word(0, 32'h1234_5678);
        finish_image();
        wait_run("t2_recover");
        check("t2_err_off", 64'(load_err), 0);

        // Full-depth image with valid toggling every other cycle.
        w0 = n_writes;
        start_image(32'd32);
        for (int k = 0; k < 32; k++) begin
            load_word(k, 32'hA500_0000 ^ (k * 32'h0001_0203));
            cycle();
        end
        finish_image();
        wait_run("t3_run");
        check("t3_writes", 64'(n_writes - w0), 32);

        // Reload from RUN drops the core immediately.
        w0 = n_writes;
        pulse_start();
        check("t5_core_off", 64'(core_en), 0);
        check("t5_done_off", 64'(load_done), 0);
        check("t5_ready", 64'(bus.data_ready), 1);
        acc = '0;
        send_word(32'd1);
        check("t5_core_off_hdr", 64'(core_en), 0);
        load_word(0, 32'hDEAD_BEEF);
        finish_image();
        wait_run("t5_run");
        check("t5_writes", 64'(n_writes - w0), 1);

        // Reset mid-load with a third word pending on the bus.
        w0 = n_writes;
        start_image(32'd4);
        load_word(0, 32'h0000_0aaa);
        load_word(1, 32'h0000_0bbb);
        bus.data_in = 32'h0000_0ccc;
        bus.data_valid = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t4_we", 64'(imem_we), 0);
        check("t4_core_en", 64'(core_en), 0);
        check("t4_ready", 64'(bus.data_ready), 0);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        check("t4_idle_ready", 64'(bus.data_ready), 0);
        bus.data_valid = 1'b0;
        check("t4_writes", 64'(n_writes - w0), 2);
        check("t4_sb_empty", 64'(exp_q.size()), 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        start_image(32'd2);
        load_word(0, 32'h1);
        load_word(1, 32'h2);
        send_word(32'h3);
        wait_run("t6_good_sum");
        start_image(32'd2);
        load_word(0, 32'h1);
        load_word(1, 32'h2);
        send_word(32'h4);
        check("t6_bad_err", 64'(load_err), 1);
        check("t6_bad_core", 64'(core_en), 0);
        cycle();
`endif

        repeat (2) cycle();
        check("final_sb_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
